// File: rtl/regfile_arb_pkg.sv
// Shared constants and state encoding for the register-file arbiter that lets a
// debug port borrow the core's register-file ports.
package regfile_arb_pkg;

  localparam int unsigned ADDR_W           = 5;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  function automatic logic core_is_idle(input logic re, input logic we);
    return !re && !we;
  endfunction

endpackage

// File: rtl/regfile_arbiter.sv
// Arbitrates the register-file ports between the core and a debug requester.
// Debug wins only when the core is idle, or after STARVE_LIMIT denied cycles.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic [ADDR_W-1:0] I_core_rs1,
  input  logic [ADDR_W-1:0] I_core_rs2,
  input  logic [ADDR_W-1:0] I_core_rd,
  input  logic              I_core_re,
  input  logic              I_core_we,
  input  logic [DATA_W-1:0] I_core_data,
  output logic              O_core_stall,
  input  logic              I_dbg_req,
  input  logic              I_dbg_we,
  input  logic [ADDR_W-1:0] I_dbg_addr,
  input  logic [DATA_W-1:0] I_dbg_wdata,
  output logic              O_dbg_ack,
  output logic [DATA_W-1:0] O_dbg_rdata,
  output logic [ADDR_W-1:0] O_rf_rs1,
  output logic [ADDR_W-1:0] O_rf_rs2,
  output logic [ADDR_W-1:0] O_rf_rd,
  output logic              O_rf_re,
  output logic              O_rf_we,
  output logic [DATA_W-1:0] O_rf_data,
  input  logic [DATA_W-1:0] I_rf_regval1
);

  localparam logic [CNT_W-1:0] LimitC = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    rdata_d      = rdata_q;
    O_rf_rs1     = I_core_rs1;
    O_rf_rs2     = I_core_rs2;
    O_rf_rd      = I_core_rd;
    O_rf_re      = I_core_re;
    O_rf_we      = I_core_we;
    O_rf_data    = I_core_data;
    O_core_stall = 1'b0;
    O_dbg_ack    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_dbg_req) begin
          if (core_is_idle(I_core_re, I_core_we) || (starve_cnt_q == LimitC)) begin
            state_d      = ST_ACCESS;
            starve_cnt_d = '0;
          end else begin
            // Reaching the limit forces a grant next cycle, so this never wraps.
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        O_rf_rs1     = I_dbg_addr;
        O_rf_rs2     = '0;
        O_rf_rd      = I_dbg_addr;
        O_rf_re      = !I_dbg_we;
        O_rf_we      = I_dbg_we;
        O_rf_data    = I_dbg_wdata;
        O_core_stall = 1'b1;
        state_d      = I_dbg_we ? ST_DONE : ST_RDWAIT;
      end

      ST_RDWAIT: begin
        // Register file is presenting the debug read; keep the ports quiet.
        O_rf_rs1     = '0;
        O_rf_rs2     = '0;
        O_rf_rd      = '0;
        O_rf_re      = 1'b0;
        O_rf_we      = 1'b0;
        O_rf_data    = '0;
        O_core_stall = 1'b1;
        rdata_d      = I_rf_regval1;
        state_d      = ST_DONE;
      end

      ST_DONE: begin
        O_dbg_ack = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  assign O_dbg_rdata = rdata_q;

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive denied IDLE cycles after which a debug request is forced through (range 1..15).
REQ-002 SHALL have ports, clock and reset first:
- I_clk  in  1  sole clock, rising edge.
- I_reset  in  1  synchronous, active-high reset.
- I_core_rs1, I_core_rs2, I_core_rd  in  5 each  core register addresses.
- I_core_re, I_core_we  in  1 each  core read/write enables.
- I_core_data  in  32  core write data.
- O_core_stall  out  1  core must hold its request and discard register read data.
- I_dbg_req  in  1  debug request, held until ack.
- I_dbg_we  in  1  1 = write, 0 = read.
- I_dbg_addr  in  5  debug register index.
- I_dbg_wdata  in  32  debug write data.
- O_dbg_ack  out  1  one-cycle completion pulse.
- O_dbg_rdata  out  32  debug read result, valid with ack.
- O_rf_rs1, O_rf_rs2, O_rf_rd  out  5 each  to register file.
- O_rf_re, O_rf_we  out  1 each  to register file.
- O_rf_data  out  32  to register file.
- I_rf_regval1  in  32  register file read port 1 (1-cycle registered latency).

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS, RDWAIT, DONE.
REQ-004 In IDLE and DONE, O_rf_* SHALL equal the core inputs combinationally and O_core_stall SHALL be 0.
REQ-005 In ACCESS: O_rf_rs1 = O_rf_rd = I_dbg_addr, O_rf_rs2 = 0, O_rf_re = !I_dbg_we, O_rf_we = I_dbg_we, O_rf_data = I_dbg_wdata, O_core_stall = 1.
REQ-006 In RDWAIT: O_rf_re = 0, O_rf_we = 0, O_core_stall = 1.
REQ-007 Core is idle when I_core_re = 0 and I_core_we = 0.
REQ-008 IDLE -> ACCESS when I_dbg_req = 1 and (core idle or starve_cnt == STARVE_LIMIT).
REQ-009 starve_cnt (4 bits) SHALL increment in IDLE when I_dbg_req = 1 and the core is not idle, saturate at STARVE_LIMIT, and clear on IDLE -> ACCESS.
REQ-010 ACCESS -> DONE when I_dbg_we = 1; ACCESS -> RDWAIT when I_dbg_we = 0.
REQ-011 RDWAIT SHALL capture I_rf_regval1 into O_dbg_rdata at its closing edge, then go to DONE.
REQ-012 DONE SHALL assert O_dbg_ack = 1 for exactly that cycle, ignore I_dbg_req, and go to IDLE.
REQ-013 O_dbg_rdata SHALL hold its value until the next debug read completes; writes SHALL leave it unchanged.
REQ-014 Latency from grant: write acks 2 cycles later; read acks 3 cycles later.
REQ-015 A debug write to index 0 SHALL complete and ack normally; the register file discards it.
REQ-016 After any stalled cycle the core SHALL reissue its read, because the register file outputs hold debug data.
REQ-017 I_dbg_req still high in IDLE after DONE SHALL be treated as a new request.
REQ-018 Debug inputs SHALL be sampled only in ACCESS; a change at any other time has no effect.

Reset
REQ-019 While I_reset = 1 at a rising edge: state = IDLE, starve_cnt = 0, O_dbg_ack = 0, O_dbg_rdata = 0.
REQ-020 Reset asserted mid-transaction SHALL abort it without an ack; an in-flight register write already issued in ACCESS is not undone.
REQ-021 O_core_stall SHALL be 0 in the cycle following reset.

Structure
REQ-022 State encoding constants and the STARVE_LIMIT default SHALL live in shared package regfile_arb_pkg.
REQ-023 The block SHALL be a single module with no sub-modules; the register file is instantiated beside it by the parent.

Verification
REQ-024 Core idle, debug write addr 5 data 0xDEADBEEF -> O_rf_we = 1 in ACCESS, ack 2 cycles after grant, then a core read of x5 returns 0xDEADBEEF.
REQ-025 Core idle, debug read of x5 -> ack 3 cycles after grant with O_dbg_rdata = 0xDEADBEEF; stall high for 2 cycles.
REQ-026 Core continuously active, dbg_req held -> grant after exactly 8 denied cycles, stall for 1 cycle (write) or 2 cycles (read), core writes during stall are not committed.
REQ-027 Debug write to x0 value 0x1 -> ack; a later debug read of x0 returns 0.
REQ-028 Reset asserted in RDWAIT -> no ack, O_dbg_rdata = 0, next cycle in IDLE with core passthrough.
REQ-029 dbg_req held high across ack -> second transaction starts from IDLE; no double ack in DONE.
